// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and its surroundings.
// The matrix lines (row/col) and the decoded key outputs.
// master: the scanner, which drives the columns and the key outputs.
// slave:  the keypad/consumer side, which drives the rows and reads the rest.
interface keypad_scanner_if;
  logic [3:0] row;             // active-low rows, asynchronous to clk
  logic [3:0] col;             // active-low column drive, exactly one bit low
  logic       keypad_pressed;  // debounced "a key is down" level
  logic [3:0] key_code;        // {row_idx, col_idx} of the last accepted key
  logic       key_valid;       // one-cycle strobe per accepted press

  modport master (
    input  row,
    output col,
    output keypad_pressed,
    output key_code,
    output key_valid
  );

  modport slave (
    output row,
    input  col,
    input  keypad_pressed,
    input  key_code,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner and debouncer.
// Walks a single low column across the matrix once per scan tick. When a
// synchronised row reads low, the column is frozen and that one row is
// debounced for press and then for release. Each accepted press produces a
// one-cycle key_valid strobe and a held key_code; keypad_pressed stays high
// from the accepted press until the accepted release.
module keypad_scanner #(
  parameter int SCAN_DIV    = 27000,  // clk cycles per scan tick
  parameter int DEBOUNCE_MS = 20      // ticks a level must hold; must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_MS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);

  localparam logic [3:0] COL_FIRST = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Synchronised rows
  logic [3:0]        rs_meta;
  logic [3:0]        rs;

  // Scan timebase
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // Controller state and its next-state values
  logic [1:0]        state,   state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [3:0]        col_q,   col_nxt;
  logic [1:0]        row_idx, row_idx_nxt;
  logic [1:0]        col_idx, col_idx_nxt;
  logic [3:0]        code_q,  code_nxt;
  logic              valid_q, valid_nxt;
  logic              pressed_q, pressed_nxt;

  // The one row being debounced reads high (key up) this cycle
  logic              row_up;

  // Next column in the walk: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] col_rotate(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  // Index of the low bit of a one-hot-low column word.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-numbered low row; row 0 has the highest priority.
  function automatic logic [1:0] low_row_index(input logic [3:0] r);
    logic [1:0] idx;
    if      (!r[0]) idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it acts only on a clock edge and
    // every register, including the synchroniser, gets its value from that edge.
    if (rst) begin
      rs_meta <= ROWS_IDLE;
      rs      <= ROWS_IDLE;
    end else begin
      // NOTE: non-blocking, so rs takes the old rs_meta and the two stages stay
      // distinct; blocking assignments would collapse them into one flop.
      rs_meta <= kp.row;
      rs      <= rs_meta;
    end
  end

  // Free-running scan timebase: one tick every SCAN_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick   = (tick_cnt == TICK_LAST);
  assign row_up = rs[row_idx];

  // Scan / debounce / hold / release decisions, taken only on tick cycles.
  always_comb begin
    // NOTE: every output gets a default before the case, so a path that does
    // not mention a signal holds its value and no latch is inferred.
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    col_nxt     = col_q;
    row_idx_nxt = row_idx;
    col_idx_nxt = col_idx;
    code_nxt    = code_q;
    valid_nxt   = 1'b0;
    pressed_nxt = pressed_q;

    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rs != ROWS_IDLE) begin
            // Freeze the column and remember which key we are looking at.
            row_idx_nxt = low_row_index(rs);
            col_idx_nxt = col_index(col_q);
            state_nxt   = ST_DEBOUNCE;
            deb_nxt     = '0;
          end else begin
            col_nxt = col_rotate(col_q);
          end
        end

        ST_DEBOUNCE: begin
          if (!row_up) begin
            if (deb_cnt == DEB_LAST) begin
              // Press accepted: strobe, raise the level and publish the code.
              state_nxt   = ST_HOLD;
              deb_nxt     = '0;
              valid_nxt   = 1'b1;
              pressed_nxt = 1'b1;
              code_nxt    = {row_idx, col_idx};
            end else begin
              deb_nxt = deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce: abandon silently and carry on walking the columns.
            state_nxt = ST_SCAN;
            deb_nxt   = '0;
            col_nxt   = col_rotate(col_q);
          end
        end

        ST_HOLD: begin
          // Only the accepted key's row matters; other rows are ignored.
          if (row_up) begin
            state_nxt = ST_RELEASE;
            deb_nxt   = '0;
          end
        end

        ST_RELEASE: begin
          if (row_up) begin
            if (deb_cnt == DEB_LAST) begin
              state_nxt   = ST_SCAN;
              deb_nxt     = '0;
              pressed_nxt = 1'b0;
              col_nxt     = col_rotate(col_q);
            end else begin
              deb_nxt = deb_cnt + DEB_W'(1);
            end
          end else begin
            // Release glitch: the key is still down, no new strobe.
            state_nxt = ST_HOLD;
            deb_nxt   = '0;
          end
        end

        default: begin
          state_nxt = ST_SCAN;
          deb_nxt   = '0;
          col_nxt   = COL_FIRST;
        end
      endcase
    end
  end

  // Controller registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      deb_cnt   <= '0;
      col_q     <= COL_FIRST;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      col_q     <= col_nxt;
      row_idx   <= row_idx_nxt;
      col_idx   <= col_idx_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
      pressed_q <= pressed_nxt;
    end
  end

  assign kp.col            = col_q;
  assign kp.key_code       = code_q;
  assign kp.key_valid      = valid_q;
  assign kp.keypad_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner.
// A virtual 4x4 keypad turns pressed keys plus the driven column into row
// levels. A tick-level reference model (run lengths of consecutive samples)
// predicts every output on every cycle; table vectors and hand sequences
// check the headline behaviours explicitly.
module tb_keypad_scanner;

  localparam int SCAN_DIV    = 4;
  localparam int DEBOUNCE_MS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held down
  logic        mon_en = 1'b0;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_valid = 0;          // key_valid pulses seen by the monitor

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low only while its column is driven low.
  function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 16; i++)
      if (k[i] && (c[i % 4] == 1'b0)) r[i / 4] = 1'b0;
    return r;
  endfunction

  assign kp.row = keypad_rows(keys, kp.col);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (tick level) ----------------
  typedef enum {M_IDLE, M_PRESSING, M_DOWN, M_LIFTING} mode_e;

  mode_e      m_mode;
  int         m_phase, m_scan, m_run, m_row;
  logic [3:0] m_sync1, m_sync2, m_s, m_code;
  logic       m_pressed, m_valid, m_tick;

  function automatic int first_low(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i] == 1'b0) return i;
    return 3;
  endfunction

  function automatic logic [3:0] model_col();
    logic [3:0] one = 4'b0001;
    return ~(one << m_scan);
  endfunction

  // A press is accepted after DEBOUNCE_MS+1 consecutive low samples of its row
  // (the detecting sample plus DEBOUNCE_MS more); release likewise with highs.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_scan = 0; m_run = 0; m_row = 0;
      m_sync1 = 4'hF; m_sync2 = 4'hF;
      m_mode = M_IDLE; m_pressed = 1'b0; m_valid = 1'b0; m_code = 4'h0;
    end else begin
      m_s     = m_sync2;
      m_tick  = (m_phase == SCAN_DIV - 1);
      m_phase = (m_phase + 1) % SCAN_DIV;
      m_valid = 1'b0;
      if (m_tick) begin
        case (m_mode)
          M_IDLE:
            if (m_s != 4'hF) begin
              m_row = first_low(m_s); m_run = 1; m_mode = M_PRESSING;
            end else m_scan = (m_scan + 1) % 4;
          M_PRESSING:
            if (m_s[m_row] == 1'b0) begin
              m_run++;
              if (m_run == DEBOUNCE_MS + 1) begin
                m_valid = 1'b1; m_pressed = 1'b1;
                m_code = 4'(m_row * 4 + m_scan);
                m_mode = M_DOWN;
              end
            end else begin
              m_mode = M_IDLE; m_scan = (m_scan + 1) % 4;
            end
          M_DOWN:
            if (m_s[m_row] == 1'b1) begin m_run = 1; m_mode = M_LIFTING; end
          M_LIFTING:
            if (m_s[m_row] == 1'b1) begin
              m_run++;
              if (m_run == DEBOUNCE_MS + 1) begin
                m_pressed = 1'b0; m_mode = M_IDLE; m_scan = (m_scan + 1) % 4;
              end
            end else m_mode = M_DOWN;
          default: m_mode = M_IDLE;
        endcase
      end
      m_sync2 = m_sync1;
      m_sync1 = kp.row;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("col", kp.col, model_col());
      check("col_onehot_low", $countones(~kp.col), 1);
      check("key_valid", kp.key_valid, m_valid);
      check("keypad_pressed", kp.keypad_pressed, m_pressed);
      check("key_code", kp.key_code, m_code);
      if (kp.key_valid === 1'b1) n_valid++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_mode(input mode_e want, input int budget, input string what);
    int found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge clk);
      if (m_mode == want) found = 1;
    end
    check(what, found, 1);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string what);
    int found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge clk);
      if (n_valid >= target) found = 1;
    end
    check(what, found, 1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [15:0] keys;
    int          hold_ticks;
    int          rel_ticks;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;     // keypad_pressed at the end of the hold phase
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    int base;
    logic [3:0] exp_col;
    logic [3:0] one;
    logic [15:0] k;
    int kind;

    vecs[0] = '{16'h0200, 12, 8, 1, 4'h9, 1'b1};  // row2/col1: code 9
    vecs[1] = '{16'h0008, 12, 8, 1, 4'h3, 1'b1};  // row0/col3
    vecs[2] = '{16'h4000, 12, 8, 1, 4'hE, 1'b1};  // row3/col2
    vecs[3] = '{16'h0010,  2, 8, 0, 4'hE, 1'b0};  // 2-tick bounce, code kept
    vecs[4] = '{16'h8000, 12, 8, 1, 4'hF, 1'b1};  // row3/col3
    vecs[5] = '{16'h0101, 12, 8, 1, 4'h0, 1'b1};  // rows 0 and 2 on col0: row0 wins
    vecs[6] = '{16'h0040,  3, 8, 0, 4'h0, 1'b0};  // DEBOUNCE_MS ticks only: rejected

    // Reset for 10 clocks with all rows idle.
    rst = 1'b1; keys = '0;
    @(negedge clk);
    mon_en = 1'b1;
    wait_clk(9);
    check("reset_col", kp.col, 4'b1110);
    check("reset_pressed", kp.keypad_pressed, 1'b0);
    check("reset_valid", kp.key_valid, 1'b0);
    check("reset_code", kp.key_code, 4'h0);

    // Idle scan: column steps every SCAN_DIV clocks after reset release.
    rst = 1'b0;
    one = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_col = ~(one << ((c / SCAN_DIV) % 4));
      check($sformatf("idle_col_%0d", c), kp.col, exp_col);
    end

    // Table-driven presses.
    for (int i = 0; i < NV; i++) begin
      base = n_valid;
      keys = vecs[i].keys;
      wait_clk(SCAN_DIV * vecs[i].hold_ticks);
      check($sformatf("vec%0d_held", i), kp.keypad_pressed, vecs[i].exp_held);
      keys = '0;
      wait_clk(SCAN_DIV * vecs[i].rel_ticks);
      check($sformatf("vec%0d_pulses", i), n_valid - base, vecs[i].exp_pulses);
      check($sformatf("vec%0d_code", i), kp.key_code, vecs[i].exp_code);
      check($sformatf("vec%0d_released", i), kp.keypad_pressed, 1'b0);
    end

    // Long hold, then a one-tick low glitch during release.
    base = n_valid;
    keys = 16'h0020;
    wait_clk(SCAN_DIV * 100);
    check("long_hold_pressed", kp.keypad_pressed, 1'b1);
    keys = '0;
    wait_mode(M_LIFTING, 40, "glitch_reach_release");
    keys = 16'h0020;
    wait_clk(SCAN_DIV);
    keys = '0;
    wait_clk(SCAN_DIV * 2);
    check("glitch_still_pressed", kp.keypad_pressed, 1'b1);
    wait_clk(SCAN_DIV * 8);
    check("glitch_pulses", n_valid - base, 1);
    check("glitch_released", kp.keypad_pressed, 1'b0);
    check("glitch_code", kp.key_code, 4'h5);

    // Two rows on col0; release row0 while row2 is held -> row2 re-detected.
    base = n_valid;
    keys = 16'h0101;
    wait_pulses(base + 1, 200, "two_rows_first_accept");
    check("two_rows_first_code", kp.key_code, 4'h0);
    keys = 16'h0100;
    wait_pulses(base + 2, 200, "two_rows_second_accept");
    check("two_rows_second_code", kp.key_code, 4'h8);
    check("two_rows_pressed", kp.keypad_pressed, 1'b1);
    keys = '0;
    wait_clk(SCAN_DIV * 10);

    // Reset for one clock mid-debounce.
    base = n_valid;
    keys = 16'h0020;
    wait_mode(M_PRESSING, 100, "rst_reach_debounce");
    rst = 1'b1;
    @(negedge clk);
    check("rst_deb_col", kp.col, 4'b1110);
    check("rst_deb_pressed", kp.keypad_pressed, 1'b0);
    check("rst_deb_valid", kp.key_valid, 1'b0);
    rst = 1'b0; keys = '0;
    wait_clk(SCAN_DIV * 6);
    check("rst_deb_no_pulse", n_valid - base, 0);

    // Reset for one clock mid-hold.
    keys = 16'h0020;
    wait_mode(M_DOWN, 100, "rst_reach_hold");
    wait_clk(2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_hold_col", kp.col, 4'b1110);
    check("rst_hold_pressed", kp.keypad_pressed, 1'b0);
    check("rst_hold_valid", kp.key_valid, 1'b0);
    check("rst_hold_code", kp.key_code, 4'h0);
    rst = 1'b0; keys = '0;
    wait_clk(SCAN_DIV * 6);

    // Randomised presses, bounces and release glitches against the model.
    for (int it = 0; it < 40; it++) begin
      k = '0;
      kind = int'($urandom_range(0, 9));
      if (kind < 7) begin
        k[$urandom_range(0, 15)] = 1'b1;
      end else if (kind < 9) begin
        k[$urandom_range(0, 15)] = 1'b1;
        k[$urandom_range(0, 15)] = 1'b1;
      end
      keys = k;
      wait_clk(SCAN_DIV * int'($urandom_range(1, 14)));
      keys = '0;
      wait_clk(SCAN_DIV * int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        keys = k;
        wait_clk(SCAN_DIV);
        keys = '0;
      end
      wait_clk(SCAN_DIV * int'($urandom_range(2, 8)));
    end

    keys = '0;
    wait_clk(SCAN_DIV * 12);
    check("final_released", kp.keypad_pressed, 1'b0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
